// File: rtl/ds1302_responder.sv
// DS1302 3-wire RTC slave: single-byte register read/write over SCLK/CE/SIO
// plus a free-running BCD hh:mm:ss clock with write-protect and clock-halt.
module ds1302_responder #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rtc_sclk,
  input  logic        rtc_rst,
  input  logic        sio_i,
  output logic        sio_o,
  output logic        sio_oe,
  output logic [23:0] time_bcd
);

  localparam int CW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  logic [2:0]    sclk_q;
  logic [1:0]    ce_q, sio_q;
  logic          rise_q, fall_q;
  state_t        state_q;
  logic [2:0]    cnt_q;
  logic [6:0]    sh_q;
  logic [4:0]    addr_q;
  logic [7:0]    rd_q;
  logic [3:0]    rcnt_q;
  logic [7:0]    regs_q [8];
  logic [CW-1:0] tick_q;
  logic          sio_o_q, oe_q;
  logic [23:0]   time_q;

  logic [7:0] byte_w, sec_n, min_n, hour_n;
  logic       wr_ok, tick, hold;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim)          return 8'h00;
    if (v[3:0] >= 4'd9)    return {v[7:4] + 4'd1, 4'h0};
    return v + 8'd1;
  endfunction

  // Byte as it stands once the bit being sampled now is shifted in.
  assign byte_w = {sio_q[1], sh_q};
  assign wr_ok  = (state_q == WDATA) && ce_q[1] && rise_q && (cnt_q == 3'd7) &&
                  (addr_q[4:3] == 2'b00) && ((addr_q[2:0] == 3'd7) || !regs_q[7][7]);
  assign hold   = wr_ok && (addr_q[2:0] < 3'd3);
  assign tick   = (tick_q == CW'(CLK_FREQ - 1));

  always_comb begin
    sec_n  = bcd_inc(regs_q[0], 8'h59);
    min_n  = regs_q[1];
    hour_n = regs_q[2];
    if (regs_q[0] >= 8'h59) begin
      min_n = bcd_inc(regs_q[1], 8'h59);
      if (regs_q[1] >= 8'h59) hour_n = bcd_inc(regs_q[2], 8'h23);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= '0;
      ce_q    <= '0;
      sio_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      rcnt_q  <= '0;
      tick_q  <= '0;
      sio_o_q <= 1'b0;
      oe_q    <= 1'b0;
      time_q  <= '0;
      regs_q[0] <= 8'h00;
      regs_q[1] <= 8'h00;
      regs_q[2] <= 8'h00;
      regs_q[3] <= 8'h01;
      regs_q[4] <= 8'h01;
      regs_q[5] <= 8'h01;
      regs_q[6] <= 8'h00;
      regs_q[7] <= 8'h80;
    end else begin
      sclk_q <= {sclk_q[1:0], rtc_sclk};
      ce_q   <= {ce_q[0], rtc_rst};
      sio_q  <= {sio_q[0], sio_i};
      rise_q <= sclk_q[1] & ~sclk_q[2];
      fall_q <= ~sclk_q[1] & sclk_q[2];
      time_q <= {regs_q[2], regs_q[1], 1'b0, regs_q[0][6:0]};

      tick_q <= tick ? '0 : tick_q + 1'b1;
      // A time-register commit on a tick cycle drops that whole increment.
      if (tick && !regs_q[0][7] && !hold) begin
        regs_q[0] <= sec_n;
        regs_q[1] <= min_n;
        regs_q[2] <= hour_n;
      end
      if (wr_ok) begin
        case (addr_q[2:0])
          3'd0: begin
            regs_q[0] <= byte_w;
            tick_q    <= '0;
          end
          3'd2:    regs_q[2] <= {1'b0, byte_w[6:0]};
          3'd7:    regs_q[7] <= {byte_w[7], 7'b0};
          default: regs_q[addr_q[2:0]] <= byte_w;
        endcase
      end

      if (!ce_q[1]) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CMD;
            cnt_q   <= '0;
          end
          CMD: if (rise_q) begin
            sh_q  <= byte_w[7:1];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              addr_q <= byte_w[5:1];
              if (!byte_w[7] || byte_w[6] || (byte_w[5:1] == 5'd31)) state_q <= DONE;
              else if (!byte_w[0]) state_q <= WDATA;
              else begin
                state_q <= RDATA;
                rcnt_q  <= '0;
                rd_q    <= (byte_w[5:4] == 2'b00) ? regs_q[byte_w[3:1]] : 8'h00;
              end
            end
          end
          WDATA: if (rise_q) begin
            sh_q  <= byte_w[7:1];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= DONE;
          end
          RDATA: if (fall_q) begin
            if (rcnt_q == 4'd8) begin
              oe_q    <= 1'b0;
              state_q <= DONE;
            end else begin
              oe_q    <= 1'b1;
              sio_o_q <= rd_q[0];
              rd_q    <= {1'b0, rd_q[7:1]};
              rcnt_q  <= rcnt_q + 4'd1;
            end
          end
          DONE:    ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sio_o    = sio_o_q;
  assign sio_oe   = oe_q;
  assign time_bcd = time_q;

endmodule

// File: tb/tb_ds1302_responder.sv
// Randomized bench for ds1302_responder: a cycle-level behavioural model of the
// RTC (events scheduled by the serial driver) is compared every clock.
module tb_ds1302_responder;
  localparam int F = 1024;
  localparam int K_SNAP = 0, K_BIT = 1, K_OFF = 2, K_WR = 3;

  logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, ce = 1'b0, sio_in = 1'b0;
  logic        sio_o, sio_oe;
  logic [23:0] time_bcd;

  ds1302_responder #(.CLK_FREQ(F)) dut (
    .clk(clk), .rst(rst), .rtc_sclk(sclk), .rtc_rst(ce), .sio_i(sio_in),
    .sio_o(sio_o), .sio_oe(sio_oe), .time_bcd(time_bcd)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; int kind; logic [7:0] a; logic [7:0] d; } ev_t;
  ev_t ev_q[$];
  int cyc = 0, m_cnt = 0, ei;
  logic [7:0] m_r [8];
  logic [7:0] m_snap = 8'h00, wa, wd;
  logic m_oe = 1'b0, m_sio = 1'b0;
  logic [23:0] exp_time = 24'h0;
  bit chk_en = 1'b0, m_tick, m_wr, m_eff;

  function automatic logic [7:0] binc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim) return 8'h00;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return v + 8'd1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_r[0] = 8'h00; m_r[1] = 8'h00; m_r[2] = 8'h00; m_r[3] = 8'h01;
      m_r[4] = 8'h01; m_r[5] = 8'h01; m_r[6] = 8'h00; m_r[7] = 8'h80;
      m_cnt = 0; m_oe = 1'b0; exp_time = 24'h0;
      ev_q.delete();
    end else begin
      exp_time = {m_r[2], m_r[1], 1'b0, m_r[0][6:0]};
      m_tick = (m_cnt == F - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      m_wr = 1'b0;
      ei = 0;
      while (ei < ev_q.size()) begin
        if (ev_q[ei].cyc == cyc) begin
          case (ev_q[ei].kind)
            K_SNAP: m_snap = m_r[ev_q[ei].a[2:0]];
            K_BIT:  begin m_oe = 1'b1; m_sio = m_snap[ev_q[ei].d[2:0]]; end
            K_OFF:  m_oe = 1'b0;
            default: begin m_wr = 1'b1; wa = ev_q[ei].a; wd = ev_q[ei].d; end
          endcase
          ev_q.delete(ei);
        end else ei++;
      end
      m_eff = m_wr && (wa == 8'd7 || !m_r[7][7]);
      if (m_tick && !m_r[0][7] && !(m_eff && wa < 8'd3)) begin
        if (m_r[0] >= 8'h59) begin
          if (m_r[1] >= 8'h59) m_r[2] = binc(m_r[2], 8'h23);
          m_r[1] = binc(m_r[1], 8'h59);
        end
        m_r[0] = binc(m_r[0], 8'h59);
      end
      if (m_eff) begin
        if (wa == 8'd7) m_r[7] = {wd[7], 7'b0};
        else if (wa == 8'd2) m_r[2] = {1'b0, wd[6:0]};
        else m_r[wa[2:0]] = wd;
        if (wa == 8'd0) m_cnt = 0;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("time_bcd", time_bcd, exp_time);
    check("sio_oe", sio_oe, m_oe);
    if (m_oe) check("sio_o", sio_o, m_sio);
  end

  // ---------------- serial master ----------------
  int hp = 5;
  task automatic waitn(input int n); repeat (n) @(negedge clk); endtask
  task automatic half(); repeat (hp) @(negedge clk); endtask

  // Pin change at this negedge becomes visible to the DUT logic dly posedges later.
  task automatic post(input int dly, input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc = cyc + dly; e.kind = kind; e.a = a; e.d = d;
    ev_q.push_back(e);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [7:0] wdat, input int nbits,
                      input int extra, input bit collide, output logic [7:0] rd);
    bit valid, isrd;
    int g;
    valid = cmd[7] && !cmd[6] && (cmd[5:1] != 5'd31);
    isrd  = valid && cmd[0];
    rd = 8'h00;
    @(negedge clk); ce = 1'b1;
    waitn(5);
    for (int i = 0; i < 8; i++) begin
      sio_in = cmd[i];
      half(); sclk = 1'b1;
      if (i == 7 && isrd) post(4, K_SNAP, {3'b0, cmd[5:1]}, 8'h0);
      half(); sclk = 1'b0;
      if (i == 7 && isrd) post(4, K_BIT, 8'h0, 8'h0);
    end
    if (isrd) begin
      for (int j = 0; j < 8; j++) begin
        half(); rd[j] = sio_o; sclk = 1'b1;
        half(); sclk = 1'b0;
        post(4, (j < 7) ? K_BIT : K_OFF, 8'h0, 8'(j + 1));
      end
    end else begin
      for (int j = 0; j < (valid ? nbits : 8); j++) begin
        sio_in = valid ? wdat[j] : 1'($urandom);
        half();
        if (valid && j == 7 && collide) begin
          g = 0;
          while (m_cnt != F - 4 && g < 2 * F) begin @(negedge clk); g++; end
          check("collide_wait_bound", 32'(g < 2 * F), 32'd1);
        end
        sclk = 1'b1;
        if (valid && j == 7) post(4, K_WR, {3'b0, cmd[5:1]}, wdat);
        half(); sclk = 1'b0;
      end
    end
    for (int e = 0; e < extra; e++) begin
      half(); sclk = 1'b1; half(); sclk = 1'b0;
    end
    waitn(5); ce = 1'b0; post(3, K_OFF, 8'h0, 8'h0);
    waitn(5);
  endtask

  task automatic wr(input logic [7:0] cmd, input logic [7:0] d);
    logic [7:0] dummy;
    xfer(cmd, d, 8, 0, 1'b0, dummy);
  endtask

  logic [7:0] b, cmd, d;
  int r, nb;

  initial begin
    waitn(3);
    chk_en = 1'b1;
    check("reset_time", time_bcd, 24'h0);
    check("reset_oe", sio_oe, 1'b0);
    check("reset_sio", sio_o, 1'b0);
    rst = 1'b0;

    xfer(8'h8F, 8'h0, 8, 0, 1'b0, b);  check("rd_ctrl_reset", b, 8'h80);
    wr(8'h80, 8'h30);
    xfer(8'h81, 8'h0, 8, 0, 1'b0, b);  check("wp_blocks_sec", b, 8'h00);

    wr(8'h8E, 8'h00); wr(8'h84, 8'h23); wr(8'h82, 8'h59); wr(8'h80, 8'h58);
    waitn(F); check("tick1_235959", time_bcd, 24'h235959);
    waitn(F); check("rollover_000000", time_bcd, 24'h000000);

    wr(8'h80, 8'h80);                  check("ch_write", time_bcd, 24'h0);
    waitn(5 * F);                      check("ch_halted", time_bcd, 24'h0);
    xfer(8'h81, 8'h0, 8, 0, 1'b0, b);  check("rd_sec_ch", b, 8'h80);

    xfer(8'h82, 8'h45, 4, 0, 1'b0, b); check("abort_min", time_bcd, 24'h0);

    wr(8'h84, 8'h12);
    xfer(8'h85, 8'h0, 8, 3, 1'b0, b);  check("rd_hour", b, 8'h12);
    check("hour_time", time_bcd, 24'h120000);

    wr(8'h80, 8'h80); wr(8'h84, 8'h10); wr(8'h82, 8'h20); wr(8'h80, 8'h59);
    xfer(8'h82, 8'h30, 8, 0, 1'b1, b); check("collide_drop", time_bcd, 24'h103059);
    waitn(F);                          check("after_collide", time_bcd, 24'h103100);

    wr(8'h8E, 8'h00); wr(8'h80, 8'h00);
    repeat (40) begin
      hp = $urandom_range(4, 6);
      r  = $urandom_range(0, 9);
      d  = 8'($urandom);
      cmd = {2'b10, 2'b00, 3'($urandom_range(0, 7)), 1'b0};
      if (r < 2) begin
        if ($urandom_range(0, 2) == 0) cmd = {1'b0, 7'($urandom)};
        else if ($urandom_range(0, 1) == 0) cmd = {2'b11, 6'($urandom)};
        else cmd = {2'b10, 5'd31, 1'($urandom)};
        xfer(cmd, d, 8, 0, 1'b0, b);
      end else if (r < 6) begin
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : 8;
        if (cmd[3:1] == 3'd0 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
        xfer(cmd, d, nb, 0, 1'b0, b);
      end else begin
        cmd[0] = 1'b1;
        xfer(cmd, 8'h0, 8, $urandom_range(0, 2), 1'b0, b);
      end
      waitn($urandom_range(0, 600));
    end

    hp = 5;
    rst = 1'b1; waitn(2); rst = 1'b0;
    check("rst_time", time_bcd, 24'h0);
    xfer(8'h8F, 8'h0, 8, 0, 1'b0, b);  check("rst_ctrl", b, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
